io_peripherals: RTL and testbench
=================================

# io_peripherals

Memory-mapped switch/LED peripheral between the ARM core's data bus and the board pins inside `top`. Synchronizes and debounces the 10 slide switches, latches per-switch change flags, and drives the 10 LEDs from a bus-writable register with set/clear/toggle aliases. Its combinational read data is returned to the core on the same cycle as the access, alongside data memory.

## Interface
- `BASE_ADDR`, 32'hFFFF_0000, byte base of the 32-byte register window; bits [4:0] must be 0.
- `DEBOUNCE_CYCLES`, 50000, consecutive stable cycles required to accept a switch change; range 1..2^CNT_W-1.
- `CNT_W`, 16, debounce counter width.
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `addr`  in  32  byte address from core.
- `we`  in  1  write strobe, sampled at rising edge when `addr` hits window.
- `wdata`  in  32  write data; only [9:0] used.
- `rdata`  out  32  read data, combinational; [31:10] always 0.
- `hit`  out  1  combinational, `addr[31:5] == BASE_ADDR[31:5]`; top uses it to mux `rdata` over memory.
- `switches`  in  10  raw asynchronous switch pins.
- `leds`  out  10  LED register output, registered.
- `irq`  out  1  `|(SW_CHG & IRQ_EN)`, driven from flops only.

## Operation
- Register map (offset = `addr[4:2]`, `addr[1:0]` ignored):
  - 0x00 SW_RAW RO: synchronizer stage-2 value.
  - 0x04 SW_DB RO: debounced switches.
  - 0x08 SW_CHG RW1C: sticky per-bit flag, set when the SW_DB bit changes.
  - 0x0C LED RW: writes load `wdata[9:0]`.
  - 0x10 LED_SET WO: LED |= wdata; 0x14 LED_CLR WO: LED &= ~wdata; 0x18 LED_TOG WO: LED ^= wdata; reads return 0.
  - 0x1C IRQ_EN RW: per-switch interrupt enable.
- Writes outside the window or with `we`=0 have no effect. Reads of WO registers return 0.
- Synchronizer: two flops per bit (sync1, sync2).
- Debounce per bit: counter cleared when sync2 == db.
  - While they differ, the counter increments each cycle.
  - On the cycle the counter equals DEBOUNCE_CYCLES-1 and they still differ, db takes sync2 and the counter clears.
  - Any intervening return to equality restarts the count from 0.
- SW_CHG: on the same edge a db bit changes, the corresponding flag is set.
  - A write-1-to-clear on that same edge loses: the set wins.
  - Writing 0 bits leaves flags unchanged.

## Timing
- Reset values: sync1, sync2, db, counters, SW_CHG, LED, IRQ_EN = 0.
  - Outputs: `leds`=0, `irq`=0, `rdata` reflects zeroed registers.
- Switches high at reset release are treated as changes: they debounce normally and set SW_CHG.
- Switch input latency: a value first sampled by sync1 at edge N is in sync2 at N+1.
  - It is in SW_DB/SW_CHG at edge N+1+DEBOUNCE_CYCLES if held stable.
  - `irq` follows on the same edge, when enabled.
- Bus writes: register updated at the edge where `we`=1; `leds` changes at that edge (0-cycle write latency, visible next cycle).
- Reads: zero latency, `rdata` valid in the same cycle from current register values.
- Reset asserted mid-debounce: counters and db clear at once; the count restarts after release.

## Structure
- Package `io_pkg`:
  - `NUM_SW`=10;
  - register offset constants (`OFF_SW_RAW` … `OFF_IRQ_EN`);
  - typedef `sw_vec_t` = logic [NUM_SW-1:0].
- Sub-module `sw_debounce`: one bit (sync1/sync2, counter, db, `changed` pulse), parameters DEBOUNCE_CYCLES and CNT_W.
  - `io_peripherals` generates NUM_SW instances.
  - It holds the address decode, LED, SW_CHG and IRQ_EN registers, and the read mux.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and clk period 10.
- Reset then `switches`=10'd4 held: SW_RAW reads 0x004 after 2 edges, then SW_DB=0x004 and SW_CHG=0x004 exactly 5 edges after first sample; `irq` stays 0 (IRQ_EN=0).
- Glitch: bit 0 pulses high for 3 cycles then low: SW_DB bit 0 never changes, SW_CHG stays 0.
- Write LED=0x0F0, LED_SET=0x001, LED_CLR=0x010, LED_TOG=0x300: `leds` = 0x0F0, 0x0F1, 0x0E1, 0x3E1 after successive writes; reading LED_SET returns 0.
- IRQ_EN=0x004, SW_CHG=0x004: `irq`=1; write SW_CHG=0x004 → `irq`=0 next cycle; write on an address outside the window changes nothing and `hit`=0.
- Write SW_CHG=0x004 on the same edge bit 2 debounces a new change: flag stays 1.
- Assert `reset` mid-count and mid-LED pattern: `leds`=0, SW_DB=0 immediately, before the next clock edge.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and types for the switch/LED peripheral.
package io_pkg;

  localparam int NUM_SW = 10;

  localparam logic [4:0] OFF_SW_RAW  = 5'h00;
  localparam logic [4:0] OFF_SW_DB   = 5'h04;
  localparam logic [4:0] OFF_SW_CHG  = 5'h08;
  localparam logic [4:0] OFF_LED     = 5'h0C;
  localparam logic [4:0] OFF_LED_SET = 5'h10;
  localparam logic [4:0] OFF_LED_CLR = 5'h14;
  localparam logic [4:0] OFF_LED_TOG = 5'h18;
  localparam logic [4:0] OFF_IRQ_EN  = 5'h1C;

  typedef logic [NUM_SW-1:0] sw_vec_t;

endpackage

// File: rtl/sw_debounce.sv
// One switch bit: two-flop synchronizer followed by a stable-count debouncer.
// changed is combinational and marks the edge on which db will flip.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic sync2,
  output logic db,
  output logic changed
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic [CNT_W-1:0] cnt;

  assign changed = (sync2 != db) && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      db    <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == db) begin
        cnt <= '0;
      end else if (changed) begin
        db  <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_peripherals.sv
// Memory-mapped switch/LED block: debounced switches with sticky change flags,
// LED register with set/clear/toggle aliases, and a combinational read port.
module io_peripherals
  import io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_0000,
  parameter int          DEBOUNCE_CYCLES = 50000,
  parameter int          CNT_W           = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  input  logic [9:0]  switches,
  output logic [9:0]  leds,
  output logic        irq
);

  sw_vec_t    sw_raw, sw_db, sw_changed;
  sw_vec_t    sw_chg, irq_en, led_q;
  sw_vec_t    wbits;
  logic [4:0] off;
  logic       wr;
  logic       unused_bits;

  assign hit         = (addr[31:5] == BASE_ADDR[31:5]);
  assign off         = {addr[4:2], 2'b00};
  assign wr          = we && hit;
  assign wbits       = wdata[NUM_SW-1:0];
  assign unused_bits = ^{wdata[31:NUM_SW], addr[1:0]};

  for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
    sw_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (switches[i]),
      .sync2  (sw_raw[i]),
      .db     (sw_db[i]),
      .changed(sw_changed[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q  <= '0;
      sw_chg <= '0;
      irq_en <= '0;
    end else begin
      // a debounced change on the same edge as a W1C write keeps the flag set
      if (wr && off == OFF_SW_CHG) sw_chg <= (sw_chg & ~wbits) | sw_changed;
      else                         sw_chg <= sw_chg | sw_changed;
      if (wr) begin
        case (off)
          OFF_LED:     led_q  <= wbits;
          OFF_LED_SET: led_q  <= led_q | wbits;
          OFF_LED_CLR: led_q  <= led_q & ~wbits;
          OFF_LED_TOG: led_q  <= led_q ^ wbits;
          OFF_IRQ_EN:  irq_en <= wbits;
          default: ;
        endcase
      end
    end
  end

  assign leds = led_q;
  assign irq  = |(sw_chg & irq_en);

  always_comb begin
    rdata = '0;
    case (off)
      OFF_SW_RAW: rdata[NUM_SW-1:0] = sw_raw;
      OFF_SW_DB:  rdata[NUM_SW-1:0] = sw_db;
      OFF_SW_CHG: rdata[NUM_SW-1:0] = sw_chg;
      OFF_LED:    rdata[NUM_SW-1:0] = led_q;
      OFF_IRQ_EN: rdata[NUM_SW-1:0] = irq_en;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_io_peripherals.sv
// Bench for io_peripherals with a short debounce window; expected values are
// queued as stimulus is applied and compared as the DUT is observed.
module tb_io_peripherals;
  import io_pkg::*;

  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        we, hit, irq;
  logic [9:0]  switches, leds;

  always #5 clk = ~clk;

  io_peripherals #(
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .we      (we),
    .wdata   (wdata),
    .rdata   (rdata),
    .hit     (hit),
    .switches(switches),
    .leds    (leds),
    .irq     (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: got 0x%0h, expected a queued value", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [4:0] off, output logic [31:0] d);
    addr = BASE | {27'd0, off};
    #1;
    d = rdata;
  endtask

  task automatic wr(input logic [4:0] off, input logic [31:0] d);
    addr  = BASE | {27'd0, off};
    wdata = d;
    we    = 1'b1;
    step();
    we    = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b0; we = 1'b0; addr = BASE; wdata = '0; switches = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_leds", {22'd0, leds}, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    rd(OFF_SW_DB, d);  check("rst_sw_db", d, 32'h0);
    rd(OFF_LED, d);    check("rst_led_reg", d, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    step();

    // switch latency: sample at edge 1, debounced at edge 6
    switches = 10'd4;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) push_exp("raw_e1", 32'h0);
      if (k == 2) push_exp("raw_e2", 32'h4);
      push_exp($sformatf("db_e%0d", k),  (k == 6) ? 32'h4 : 32'h0);
      push_exp($sformatf("chg_e%0d", k), (k == 6) ? 32'h4 : 32'h0);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      if (k <= 2) begin rd(OFF_SW_RAW, d); pop_check(d); end
      rd(OFF_SW_DB, d);  pop_check(d);
      rd(OFF_SW_CHG, d); pop_check(d);
    end
    check("irq_disabled", {31'd0, irq}, 32'h0);

    wr(OFF_SW_CHG, 32'h4);
    rd(OFF_SW_CHG, d); check("chg_w1c", d, 32'h0);

    // glitch one cycle short of the debounce window
    switches = 10'd5;
    repeat (3) step();
    switches = 10'd4;
    for (int k = 1; k <= 8; k++) push_exp($sformatf("glitch_db_%0d", k), 32'h4);
    push_exp("glitch_chg", 32'h0);
    for (int k = 1; k <= 8; k++) begin
      step();
      rd(OFF_SW_DB, d); pop_check(d);
    end
    rd(OFF_SW_CHG, d); pop_check(d);

    // LED aliases
    wr(OFF_LED, 32'h0F0);     check("led_load", {22'd0, leds}, 32'h0F0);
    wr(OFF_LED_SET, 32'h001); check("led_set", {22'd0, leds}, 32'h0F1);
    wr(OFF_LED_CLR, 32'h010); check("led_clr", {22'd0, leds}, 32'h0E1);
    wr(OFF_LED_TOG, 32'h300); check("led_tog", {22'd0, leds}, 32'h3E1);
    rd(OFF_LED_SET, d);       check("led_set_rd0", d, 32'h0);
    rd(OFF_LED, d);           check("led_rd", d, 32'h3E1);

    // interrupt path and out-of-window writes
    switches = 10'd0;
    repeat (7) step();
    rd(OFF_SW_CHG, d); check("chg_fall", d, 32'h4);
    check("irq_before_en", {31'd0, irq}, 32'h0);
    wr(OFF_IRQ_EN, 32'h4);
    check("irq_on", {31'd0, irq}, 32'h1);
    rd(OFF_IRQ_EN, d); check("irq_en_rd", d, 32'h4);
    addr = 32'hFFFF_0028; wdata = 32'h4; we = 1'b1;
    #1 check("hit_outside", {31'd0, hit}, 32'h0);
    step();
    addr = 32'hFFFE_000C; wdata = 32'h0;
    step();
    we = 1'b0;
    check("irq_after_outside", {31'd0, irq}, 32'h1);
    check("leds_after_outside", {22'd0, leds}, 32'h3E1);
    rd(OFF_SW_CHG, d); check("chg_after_outside", d, 32'h4);
    check("hit_inside", {31'd0, hit}, 32'h1);
    wr(OFF_SW_CHG, 32'h4);
    check("irq_cleared", {31'd0, irq}, 32'h0);

    // W1C on the very edge the flag is set: set wins
    switches = 10'd4;
    repeat (5) step();
    rd(OFF_SW_DB, d); check("db_before_race", d, 32'h0);
    wr(OFF_SW_CHG, 32'h4);
    rd(OFF_SW_DB, d);  check("db_race", d, 32'h4);
    rd(OFF_SW_CHG, d); check("chg_race", d, 32'h4);
    check("irq_race", {31'd0, irq}, 32'h1);

    // async reset mid-count
    switches = 10'd0;
    repeat (2) step();
    reset = 1'b1;
    #1;
    check("mid_rst_leds", {22'd0, leds}, 32'h0);
    check("mid_rst_irq", {31'd0, irq}, 32'h0);
    rd(OFF_SW_DB, d);  check("mid_rst_db", d, 32'h0);
    rd(OFF_SW_CHG, d); check("mid_rst_chg", d, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) step();
    rd(OFF_SW_DB, d); check("post_rst_db", d, 32'h0);

    check("sb_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
